// File: rtl/wavegen_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : wavegen_ctrl_sync
// Description : Synchronises, filters and debounces the raw wave_generator
//               control pins into clean, mutually exclusive set strobes.
//               Optional macro WAVEGEN_AUTO_REPEAT_EN adds press auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module wavegen_ctrl_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_pin_i,
  input  logic [1:0] waveform_pin_i,
  input  logic       set_phase_pin_i,
  input  logic       set_amplitude_pin_i,
  input  logic [7:0] value_pin_i,
  output logic       enable_o,
  output logic [1:0] waveform_o,
  output logic       set_phase_strobe_o,
  output logic       set_amplitude_strobe_o,
  output logic [7:0] data_o
);

  localparam int                 SW       = 13;
  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   C_DEB_M1 = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef WAVEGEN_AUTO_REPEAT_EN
  localparam int                 RPT_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0]   C_RPT_M1 = RPT_W'(REPEAT_CYCLES - 1);
`endif

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("wavegen_ctrl_sync: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMING    = 2'd1,
    S_PRESSED   = 2'd2,
    S_RELEASING = 2'd3
  } btn_state_t;

  logic [SW-1:0]                  w_pins;
  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [SW-1:0]                  w_sync;
  logic                           w_en_s;
  logic [1:0]                     w_wf_s;
  logic [1:0]                     w_btn_s;
  logic [7:0]                     w_val_s;
  logic [1:0]                     w_evt;

  logic       r_enable;
  logic [1:0] r_wf_prev;
  logic [1:0] r_waveform;
  logic       r_ph_stb;
  logic       r_amp_stb;
  logic       r_pend;
  logic [7:0] r_data;

  // All pins share one flop chain; bit order: value, amp, phase, waveform, enable
  assign w_pins  = {value_pin_i, set_amplitude_pin_i, set_phase_pin_i, waveform_pin_i, enable_pin_i};
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_en_s  = w_sync[0];
  assign w_wf_s  = w_sync[2:1];
  assign w_btn_s = w_sync[4:3];
  assign w_val_s = w_sync[12:5];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_enable   <= 1'b0;
      r_wf_prev  <= 2'b00;
      r_waveform <= 2'b00;
    end else begin
      r_enable  <= w_en_s;
      r_wf_prev <= w_wf_s;
      if (w_wf_s == r_wf_prev) begin
        r_waveform <= w_wf_s;
      end
    end
  end

  // Button 0 is set-phase, button 1 is set-amplitude
  for (genvar b = 0; b < 2; b++) begin : g_btn
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt;
`ifdef WAVEGEN_AUTO_REPEAT_EN
    logic [RPT_W-1:0] r_rpt;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_evt   <= 1'b0;
`ifdef WAVEGEN_AUTO_REPEAT_EN
        r_rpt   <= '0;
`endif
      end else begin
        r_evt <= 1'b0;
`ifdef WAVEGEN_AUTO_REPEAT_EN
        r_rpt <= '0;
`endif
        case (r_state)
          S_IDLE: begin
            if (w_btn_s[b]) begin
              r_state <= S_ARMING;
              r_cnt   <= CNT_W'(1);
            end
          end
          S_ARMING: begin
            if (!w_btn_s[b]) begin
              r_state <= S_IDLE;
            end else if (r_cnt == C_DEB_M1) begin
              r_state <= S_PRESSED;
              r_evt   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!w_btn_s[b]) begin
              r_state <= S_RELEASING;
              r_cnt   <= CNT_W'(1);
            end
`ifdef WAVEGEN_AUTO_REPEAT_EN
            else if (r_rpt == C_RPT_M1) begin
              r_evt <= 1'b1;
            end else begin
              r_rpt <= r_rpt + 1'b1;
            end
`endif
          end
          S_RELEASING: begin
            if (w_btn_s[b]) begin
              r_state <= S_PRESSED;
            end else if (r_cnt == C_DEB_M1) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign w_evt[b] = r_evt;
  end

  // Phase wins a tie; a deferred amplitude press waits in r_pend and merges
  // with any further amplitude press arriving before it is issued.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ph_stb  <= 1'b0;
      r_amp_stb <= 1'b0;
      r_pend    <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_ph_stb  <= 1'b0;
      r_amp_stb <= 1'b0;
      if (w_evt[0]) begin
        r_ph_stb <= 1'b1;
        r_data   <= w_val_s;
        r_pend   <= r_pend | w_evt[1];
      end else if (w_evt[1] || r_pend) begin
        r_amp_stb <= 1'b1;
        r_data    <= w_val_s;
        r_pend    <= 1'b0;
      end
    end
  end

  assign enable_o               = r_enable;
  assign waveform_o             = r_waveform;
  assign set_phase_strobe_o     = r_ph_stb;
  assign set_amplitude_strobe_o = r_amp_stb;
  assign data_o                 = r_data;

endmodule
`default_nettype wire

// File: doc/wavegen_ctrl_sync.md
Name: wavegen_ctrl_sync

Overview:
- Input conditioning stage directly upstream of wave_generator.
- Takes the raw, asynchronous control pins (enable, waveform select, set-phase and set-amplitude buttons, 8-bit value switches) and synchronises them into the clock domain.
- Debounces the two set buttons and converts each press into exactly one single-cycle strobe.
- Captures the matching 8-bit value so wave_generator sees clean, glitch-free, mutually exclusive strobes.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on every pin; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a button level change; minimum 2.
- REPEAT_CYCLES, 256, auto-repeat period in clock cycles; used only with WAVEGEN_AUTO_REPEAT_EN.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-low
- enable_pin_i  input  1  raw enable pin
- waveform_pin_i  input  2  raw waveform select pins
- set_phase_pin_i  input  1  raw set-phase button, active-high
- set_amplitude_pin_i  input  1  raw set-amplitude button, active-high
- value_pin_i  input  8  raw phase/amplitude value switches
- enable_o  output  1  synchronised enable
- waveform_o  output  2  synchronised, glitch-filtered waveform select
- set_phase_strobe_o  output  1  one-cycle set-phase strobe
- set_amplitude_strobe_o  output  1  one-cycle set-amplitude strobe
- data_o  output  8  value captured with the most recent strobe

Behaviour:
- Reset (rst_i low, asynchronous): all synchroniser flops, counters and FSMs clear. All outputs are 0: enable_o, waveform_o=2'b00, both strobes, data_o=8'h00. Both button FSMs go to IDLE and the pending flag clears.
- Synchronisers: every pin passes through SYNC_STAGES flops. Control decisions use only the last stage.
- enable_o: registered copy of the synchronised enable. Latency is SYNC_STAGES+1 cycles from the pin.
- waveform_o: updates only when the synchronised 2-bit value is identical on two consecutive cycles; otherwise it holds. Latency is SYNC_STAGES+2 cycles.
- Button FSM, one per button, four states with an up counter of width clog2(DEBOUNCE_CYCLES)+1:
  - IDLE: level low. Sync high -> ARMING, count=1.
  - ARMING: sync high -> count+1. Sync low -> IDLE. When count reaches DEBOUNCE_CYCLES -> PRESSED, and a press event is raised.
  - PRESSED: sync low -> RELEASING, count=1.
  - RELEASING: sync low -> count+1. Sync high -> PRESSED. When count reaches DEBOUNCE_CYCLES -> IDLE.
- One press event per accepted press. A bounce shorter than DEBOUNCE_CYCLES produces no event.
- Strobe output:
  - A press event asserts the corresponding strobe (registered) for exactly 1 cycle.
  - In the same edge, data_o loads the synchronised value. data_o holds until the next strobe.
  - Latency from the first edge sampling the pin high: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- Mutual exclusion:
  - The two strobes are never high in the same cycle.
  - If both events occur in the same cycle, phase is issued first. Amplitude is recorded in a pending flag and issued the next cycle, with data_o reloaded from the then-current synchronised value.
  - If an amplitude event occurs while pending is already set, the two merge into one strobe.
- Reset mid-debounce or mid-pending: everything is discarded and no strobe follows reset release. If a pin is held high through reset release, it goes through the full debounce before a strobe.

Optional Feature:
- Macro: WAVEGEN_AUTO_REPEAT_EN.
- Defined:
  - Each button FSM has a repeat counter that runs while in PRESSED.
  - Every REPEAT_CYCLES cycles spent in PRESSED, the FSM raises a further press event, with the same priority and pending rules.
  - The counter clears on leaving PRESSED.
- Not defined: no repeat counter is built; one strobe per press. REPEAT_CYCLES is ignored.

Test Plan:
- Reset values: assert rst_i=0 mid-cycle -> all outputs 0 immediately; release with all pins low -> outputs stay 0 for 100 cycles.
- Clean press: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, value_pin_i=8'hA5, set_phase_pin_i high for 20 cycles -> set_phase_strobe_o high exactly once, at edge 7, for 1 cycle, data_o=8'hA5 from then on; release -> no further strobes.
- Bounce: set_amplitude_pin_i toggled high 3 cycles / low 1 cycle, repeated, then steady high -> no strobe during bouncing; one strobe 7 edges after the last rising sample.
- Simultaneous press: both buttons rise on the same edge, value 8'h3C -> phase strobe at edge N, amplitude strobe at N+1, never overlapping, data_o=8'h3C at both.
- Waveform glitch: waveform_pin_i pulses 2'b11 for 1 cycle from 2'b00 -> waveform_o stays 2'b00; held 2'b10 for 3 cycles -> waveform_o=2'b10 after SYNC_STAGES+2 cycles.
- WAVEGEN_AUTO_REPEAT_EN with REPEAT_CYCLES=8, DEBOUNCE_CYCLES=4, button held 40 cycles -> initial strobe, then a strobe every 8 cycles while held (4 repeats); without the macro -> exactly 1 strobe.
